// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transceiver.
// Build option: define UART_PARITY_EN to add an even-parity bit to every frame.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  // Total line bits in one frame: start + data + optional parity + stop.
  function automatic int bits_per_frame(input int data_w);
`ifdef UART_PARITY_EN
    return data_w + 3;
`else
    return data_w + 2;
`endif
  endfunction

  // Even-parity bit for up to 9 data bits (zero-extend narrower words).
  function automatic logic even_parity(input logic [8:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO: head word is visible whenever valid is high.
// Push while full is accepted only together with a pop.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              valid,
  output logic              full
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              pop_s;
  logic              push_s;

  assign pop_s  = pop && (count_r != {CNT_W{1'b0}});
  assign push_s = push && ((count_r != DEPTH_C) || pop_s);
  assign valid  = (count_r != {CNT_W{1'b0}});
  assign full   = (count_r == DEPTH_C);
  assign rdata  = valid ? mem_r[rd_ptr_r] : {DATA_W{1'b0}};

  // Storage write; the data array itself needs no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART: TX FSM, synchronised RX FSM and a show-ahead RX FIFO.
// Build option: define UART_PARITY_EN for even parity on TX and parity checking on RX.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(bits_per_frame(DATA_W));
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  tx_state_t         tx_state_r;
  logic [BAUD_W-1:0] tx_baud_r;
  logic [BIT_W-1:0]  tx_bit_r;
  logic [DATA_W-1:0] tx_shift_r;
  logic              tx_r;
  logic              tx_ready_r;

  rx_state_t         rx_state_r;
  logic [BAUD_W-1:0] rx_baud_r;
  logic [BIT_W-1:0]  rx_bit_r;
  logic [DATA_W-1:0] rx_shift_r;
  logic              rx_sync1_r;
  logic              rx_sync2_r;
  logic              rx_prev_r;
  logic              frame_err_r;
  logic              overrun_r;

  logic              rx_s;
  logic              stop_sample_s;
  logic              parity_ok_s;
  logic              fifo_full_s;
  logic              pop_s;
  logic              push_s;

`ifdef UART_PARITY_EN
  logic              tx_par_r;
  logic              rx_par_r;
  logic              parity_err_r;
  assign parity_ok_s = (even_parity(9'(rx_shift_r)) == rx_par_r);
  assign parity_err  = parity_err_r;
`else
  assign parity_ok_s = 1'b1;
  assign parity_err  = 1'b0;
`endif

  assign tx        = tx_r;
  assign tx_ready  = tx_ready_r;
  assign frame_err = frame_err_r;
  assign overrun   = overrun_r;

  assign rx_s          = rx_sync2_r;
  assign stop_sample_s = (rx_state_r == RX_STOP) && (rx_baud_r == BAUD_LAST);
  assign pop_s         = rx_valid && rx_ready;
  assign push_s        = stop_sample_s && rx_s && parity_ok_s && (!fifo_full_s || pop_s);

  // Transmit state machine: shifts the latched word out LSB first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_r <= TX_IDLE;
      tx_baud_r  <= {BAUD_W{1'b0}};
      tx_bit_r   <= {BIT_W{1'b0}};
      tx_shift_r <= {DATA_W{1'b0}};
      tx_r       <= 1'b1;
      tx_ready_r <= 1'b1;
`ifdef UART_PARITY_EN
      tx_par_r   <= 1'b0;
`endif
    end else begin
      case (tx_state_r)
        TX_IDLE: begin
          tx_baud_r <= {BAUD_W{1'b0}};
          if (tx_valid) begin
            tx_shift_r <= tx_data;
`ifdef UART_PARITY_EN
            tx_par_r   <= even_parity(9'(tx_data));
`endif
            tx_r       <= 1'b0;
            tx_ready_r <= 1'b0;
            tx_state_r <= TX_START;
          end
        end
        TX_START: begin
          if (tx_baud_r == BAUD_LAST) begin
            tx_baud_r  <= {BAUD_W{1'b0}};
            tx_bit_r   <= {BIT_W{1'b0}};
            tx_r       <= tx_shift_r[0];
            tx_state_r <= TX_DATA;
          end else begin
            tx_baud_r <= tx_baud_r + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_baud_r == BAUD_LAST) begin
            tx_baud_r  <= {BAUD_W{1'b0}};
            tx_shift_r <= tx_shift_r >> 1;
            if (tx_bit_r == BIT_LAST) begin
`ifdef UART_PARITY_EN
              tx_r       <= tx_par_r;
              tx_state_r <= TX_PARITY;
`else
              tx_r       <= 1'b1;
              tx_state_r <= TX_STOP;
`endif
            end else begin
              tx_bit_r <= tx_bit_r + 1'b1;
              tx_r     <= tx_shift_r[1];
            end
          end else begin
            tx_baud_r <= tx_baud_r + 1'b1;
          end
        end
        TX_PARITY: begin
          if (tx_baud_r == BAUD_LAST) begin
            tx_baud_r  <= {BAUD_W{1'b0}};
            tx_r       <= 1'b1;
            tx_state_r <= TX_STOP;
          end else begin
            tx_baud_r <= tx_baud_r + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_baud_r == BAUD_LAST) begin
            tx_baud_r  <= {BAUD_W{1'b0}};
            tx_ready_r <= 1'b1;
            tx_state_r <= TX_IDLE;
          end else begin
            tx_baud_r <= tx_baud_r + 1'b1;
          end
        end
        default: begin
          tx_r       <= 1'b1;
          tx_ready_r <= 1'b1;
          tx_state_r <= TX_IDLE;
        end
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous rx line plus an edge-history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync1_r <= 1'b1;
      rx_sync2_r <= 1'b1;
      rx_prev_r  <= 1'b1;
    end else begin
      rx_sync1_r <= rx;
      rx_sync2_r <= rx_sync1_r;
      rx_prev_r  <= rx_sync2_r;
    end
  end

  // Receive state machine: centre-samples each bit and raises error pulses at the stop sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_r   <= RX_IDLE;
      rx_baud_r    <= {BAUD_W{1'b0}};
      rx_bit_r     <= {BIT_W{1'b0}};
      rx_shift_r   <= {DATA_W{1'b0}};
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_r     <= 1'b0;
      parity_err_r <= 1'b0;
`endif
    end else begin
      frame_err_r  <= 1'b0;
      overrun_r    <= 1'b0;
`ifdef UART_PARITY_EN
      parity_err_r <= 1'b0;
`endif
      case (rx_state_r)
        RX_IDLE: begin
          rx_baud_r <= {BAUD_W{1'b0}};
          if (rx_prev_r && !rx_s) begin
            rx_state_r <= RX_START;
          end
        end
        RX_START: begin
          if (rx_baud_r == BAUD_HALF) begin
            rx_baud_r  <= {BAUD_W{1'b0}};
            rx_bit_r   <= {BIT_W{1'b0}};
            rx_state_r <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_baud_r <= rx_baud_r + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_baud_r == BAUD_LAST) begin
            rx_baud_r  <= {BAUD_W{1'b0}};
            rx_shift_r <= {rx_s, rx_shift_r[DATA_W-1:1]};
            if (rx_bit_r == BIT_LAST) begin
`ifdef UART_PARITY_EN
              rx_state_r <= RX_PARITY;
`else
              rx_state_r <= RX_STOP;
`endif
            end else begin
              rx_bit_r <= rx_bit_r + 1'b1;
            end
          end else begin
            rx_baud_r <= rx_baud_r + 1'b1;
          end
        end
        RX_PARITY: begin
          if (rx_baud_r == BAUD_LAST) begin
            rx_baud_r  <= {BAUD_W{1'b0}};
`ifdef UART_PARITY_EN
            rx_par_r   <= rx_s;
`endif
            rx_state_r <= RX_STOP;
          end else begin
            rx_baud_r <= rx_baud_r + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_baud_r == BAUD_LAST) begin
            rx_baud_r  <= {BAUD_W{1'b0}};
            rx_state_r <= RX_IDLE;
            if (!rx_s) begin
              frame_err_r <= 1'b1;
`ifdef UART_PARITY_EN
            end else if (!parity_ok_s) begin
              parity_err_r <= 1'b1;
`endif
            end else if (fifo_full_s && !pop_s) begin
              overrun_r <= 1'b1;
            end
          end else begin
            rx_baud_r <= rx_baud_r + 1'b1;
          end
        end
        default: begin
          rx_state_r <= RX_IDLE;
        end
      endcase
    end
  end

  uart_rx_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .wdata (rx_shift_r),
    .pop   (pop_s),
    .rdata (rx_data),
    .valid (rx_valid),
    .full  (fifo_full_s)
  );

endmodule
